// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared cacheline geometry, line type and adaptor state encoding
package cache_types_pkg;

  // Default cacheline geometry: four 64-bit memory beats make one 256-bit line.
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  // Byte-offset bits of a line address; these are zeroed on the memory side.
  localparam int LINE_OFFSET_W = $clog2(LINE_W / 8);

  typedef logic [LINE_W-1:0] rv_line_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts whole-line fill/writeback requests into 4-beat memory bursts
module cacheline_adaptor #(
  parameter int LINE_W  = cache_types_pkg::LINE_W,
  parameter int BURST_W = cache_types_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  import cache_types_pkg::*;

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  // Lines are held beat-addressable so the counter indexes a beat directly.
  typedef logic [NBEATS-1:0][BURST_W-1:0] beat_line_t;

  adaptor_state_t   state_q,   state_d;
  logic [CNT_W-1:0] beat_q,    beat_d;
  logic [31:0]      addr_q,    addr_d;
  beat_line_t       wline_q,   wline_d;
  beat_line_t       fill_q,    fill_d;
  logic             read_o_q,  read_o_d;
  logic             write_o_q, write_o_d;
  logic             resp_o_q,  resp_o_d;
  logic [BURST_W-1:0] burst_o_q, burst_o_d;

  // The low address bits only select bytes within the line and never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[OFF_W-1:0];

  // Next-state, beat bookkeeping and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    fill_d    = fill_q;
    read_o_d  = 1'b0;
    write_o_d = 1'b0;
    resp_o_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A writeback wins over a simultaneous fill so the victim leaves first.
        if (write_i) begin
          addr_d    = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          wline_d   = line_i;
          beat_d    = '0;
          state_d   = ST_WR_BURST;
          write_o_d = 1'b1;
        end else if (read_i) begin
          addr_d   = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          beat_d   = '0;
          state_d  = ST_RD_BURST;
          read_o_d = 1'b1;
        end
      end

      ST_RD_BURST: begin
        read_o_d = 1'b1;
        if (resp_i) begin
          fill_d[beat_q] = burst_i;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            state_d  = ST_DONE;
            read_o_d = 1'b0;
            resp_o_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_WR_BURST: begin
        write_o_d = 1'b1;
        if (resp_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            state_d   = ST_DONE;
            write_o_d = 1'b0;
            resp_o_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        // One-cycle completion; any still-high request is picked up fresh in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The write beat is registered from the next beat index so it lines up with write_o.
    burst_o_d = (state_d == ST_WR_BURST) ? wline_d[beat_d] : '0;
  end

  // All adaptor state and outputs; synchronous reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      wline_q   <= '0;
      fill_q    <= '0;
      read_o_q  <= 1'b0;
      write_o_q <= 1'b0;
      resp_o_q  <= 1'b0;
      burst_o_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wline_q   <= wline_d;
      fill_q    <= fill_d;
      read_o_q  <= read_o_d;
      write_o_q <= write_o_d;
      resp_o_q  <= resp_o_d;
      burst_o_q <= burst_o_d;
    end
  end

  assign line_o    = fill_q;
  assign address_o = addr_q;
  assign read_o    = read_o_q;
  assign write_o   = write_o_q;
  assign resp_o    = resp_o_q;
  assign burst_o   = burst_o_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - randomized self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference: the last line delivered by a completed fill (cleared by reset).
  logic [255:0] last_fill = '0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // Memory strobe policy: 0 = every cycle, 1 = fixed 1,0,0,1,1,0,1 pattern, 2 = random.
  function automatic logic pick_resp(input int mode, input int idx);
    logic [6:0] pat;
    pat = 7'b1011001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[idx % 7];
      default: return ($urandom_range(0, 9) < 6);
    endcase
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fill request: acts as memory, builds the expected line from the beats it returns.
  task automatic do_read(input logic [31:0] addr, input int mode, input bit directed, output int lat);
    logic [255:0] exp_line;
    logic [63:0]  data;
    logic [7:0]   b;
    int k, opp;
    bit done, bad_addr, overlap;
    exp_line = last_fill;
    k = 0; opp = 0; done = 0; bad_addr = 0; overlap = 0;
    address_i = addr;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    lat       = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      lat++;
      if (write_o || burst_o != 64'd0) overlap = 1;
      if (resp_o) begin
        done = 1;
      end else if (read_o) begin
        if (address_o != line_addr(addr)) bad_addr = 1;
        resp_i = pick_resp(mode, opp);
        opp++;
        if (resp_i) begin
          b    = 8'(17 * (k + 1));
          data = directed ? {8{b}} : rand64();
          burst_i = data;
          if (k < 4) exp_line[64*k +: 64] = data;
          k++;
        end else begin
          burst_i = rand64();
        end
      end else begin
        resp_i = 1'b0;
      end
    end
    check("rd_done", 32'(done), 32'd1);
    check("rd_beats", 32'(k), 32'd4);
    check("rd_line", line_o, exp_line);
    check("rd_addr", address_o, line_addr(addr));
    check("rd_addr_stable", 32'(bad_addr), 32'd0);
    check("rd_no_write_side", 32'(overlap), 32'd0);
    last_fill = exp_line;
    read_i = 1'b0;
    resp_i = 1'b0;
    tick();
    check("rd_resp_single", 32'(resp_o), 32'd0);
    check("rd_read_o_low", 32'(read_o), 32'd0);
    check("rd_line_hold", line_o, last_fill);
  endtask

  // Writeback request: checks each presented beat against the requested line.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int mode,
                          input bit also_read);
    int k, opp;
    bit done, bad_beat, overlap, bad_addr;
    k = 0; opp = 0; done = 0; bad_beat = 0; overlap = 0; bad_addr = 0;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = also_read;
    resp_i    = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      line_i = rand256();
      if (read_o) overlap = 1;
      if (resp_o) begin
        done = 1;
      end else if (write_o) begin
        if (address_o != line_addr(addr)) bad_addr = 1;
        if (k < 4 && burst_o != line[64*k +: 64]) bad_beat = 1;
        resp_i = pick_resp(mode, opp);
        opp++;
        burst_i = rand64();
        if (resp_i) k++;
      end else begin
        if (burst_o != 64'd0) bad_beat = 1;
        resp_i = 1'b0;
      end
    end
    check("wr_done", 32'(done), 32'd1);
    check("wr_beats", 32'(k), 32'd4);
    check("wr_beat_data", 32'(bad_beat), 32'd0);
    check("wr_no_read_o", 32'(overlap), 32'd0);
    check("wr_addr_stable", 32'(bad_addr), 32'd0);
    check("wr_write_o_low", 32'(write_o), 32'd0);
    check("wr_burst_o_zero", 64'(burst_o), 64'd0);
    check("wr_fill_untouched", line_o, last_fill);
    write_i = 1'b0;
    resp_i  = 1'b0;
    tick();
    check("wr_resp_single", 32'(resp_o), 32'd0);
  endtask

  // Reset after beat 2 of a fill: the burst dies with no completion and a cleared line.
  task automatic do_read_abort(input logic [31:0] addr);
    int k;
    bit seen_resp;
    k = 0; seen_resp = 0;
    address_i = addr;
    read_i    = 1'b1;
    for (int cyc = 0; cyc < 50 && k < 3; cyc++) begin
      tick();
      if (read_o) begin
        resp_i  = 1'b1;
        burst_i = rand64();
        k++;
      end
    end
    tick();
    rst    = 1'b1;
    resp_i = 1'b0;
    read_i = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_read_o", 32'(read_o), 32'd0);
    check("abort_line_o", line_o, 256'd0);
    check("abort_resp_o", 32'(resp_o), 32'd0);
    check("abort_address_o", address_o, 32'd0);
    last_fill = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_o || read_o) seen_resp = 1;
    end
    check("abort_quiet", 32'(seen_resp), 32'd0);
  endtask

  // Idle cycles with stray memory strobes, which must change nothing.
  task automatic idle(input int n);
    bit busy;
    busy = 0;
    read_i  = 1'b0;
    write_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      resp_i  = $urandom_range(0, 1);
      burst_i = rand64();
      tick();
      if (resp_o || read_o || write_o) busy = 1;
    end
    resp_i = 1'b0;
    check("idle_quiet", 32'(busy), 32'd0);
    check("idle_line_hold", line_o, last_fill);
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    repeat (3) tick();
    check("rst_read_o", 32'(read_o), 32'd0);
    check("rst_write_o", 32'(write_o), 32'd0);
    check("rst_resp_o", 32'(resp_o), 32'd0);
    check("rst_address_o", address_o, 32'd0);
    check("rst_burst_o", 64'(burst_o), 64'd0);
    check("rst_line_o", line_o, 256'd0);
    rst = 1'b0;
    tick();

    // Directed fill with back-to-back beats.
    do_read(32'h1234_5678, 0, 1'b1, lat);
    check("rd_latency", 32'(lat), 32'd6);
    check("rd_dir_line", line_o, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    check("rd_dir_addr", address_o, 32'h1234_5660);

    // Directed writeback.
    do_write(32'hABCD_EF3F, 256'h0123456789ABCDEF_FEDCBA9876543210_5A5A5A5AA5A5A5A5_44332211DDCCBBAA,
             0, 1'b0);
    idle(3);

    // Stalled fill.
    do_read(32'h0000_1000, 1, 1'b0, lat);

    // Simultaneous requests: writeback first, then the still-held fill.
    a = $urandom;
    do_write(a, rand256(), 2, 1'b1);
    do_read(a, 2, 1'b0, lat);

    // Reset mid-fill, then a clean fill.
    do_read_abort(32'h8000_0040);
    do_read(32'h8000_0040, 0, 1'b0, lat);

    // Eviction: writeback immediately followed by a fill.
    do_write($urandom, rand256(), 2, 1'b0);
    do_read($urandom, 2, 1'b0, lat);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, $urandom_range(0, 2), 1'b0, lat);
      else
        do_write($urandom, rand256(), $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
